// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-like port arbiter.
package sram_arb_pkg;

    // Address-phase routing state: free arbitration, or stuck on one master
    // until the downstream port accepts its request.
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Master identifiers, also the payload stored in the order queue.
    localparam logic INST = 1'b0;
    localparam logic DATA = 1'b1;

    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// SRAM-like bus: req/addr_ok address phase, data_ok/rdata data phase.
interface sram_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Requesting side of the bus.
    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Responding side of the bus.
    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_arbiter_order_fifo.sv
// 1-bit-wide FIFO recording which master owns each outstanding request.
module arb_order_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between the instruction and data masters.
// Data has fixed priority; a stalled request is held until accepted and
// responses are steered back in issue order via a small ID queue.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave  inst,
    sram_arbiter_if.slave  data,
    sram_arbiter_if.master mem,
    output logic          err_orphan
);

    arb_state_t state;
    logic       hold_id;
    logic       win_id;
    logic       grant_req;
    logic       q_push;
    logic       q_pop;
    logic       q_head;
    logic       q_full;
    logic       q_empty;

    // Pick the routed master: held master in HOLD, else data-over-inst when room remains.
    always_comb begin
        win_id    = INST;
        grant_req = 1'b0;
        if (!rst) begin
            if (state == HOLD) begin
                win_id    = hold_id;
                grant_req = (hold_id == DATA) ? data.req : inst.req;
            end else if (!q_full) begin
                if (data.req) begin
                    win_id    = DATA;
                    grant_req = 1'b1;
                end else if (inst.req) begin
                    win_id    = INST;
                    grant_req = 1'b1;
                end
            end
        end
    end

    assign mem.req   = grant_req;
    assign mem.wr    = (win_id == DATA) ? data.wr    : inst.wr;
    assign mem.size  = (win_id == DATA) ? data.size  : inst.size;
    assign mem.wstrb = (win_id == DATA) ? data.wstrb : inst.wstrb;
    assign mem.addr  = (win_id == DATA) ? data.addr  : inst.addr;
    assign mem.wdata = (win_id == DATA) ? data.wdata : inst.wdata;

    assign inst.addr_ok = grant_req && mem.addr_ok && (win_id == INST);
    assign data.addr_ok = grant_req && mem.addr_ok && (win_id == DATA);

    assign q_push = grant_req && mem.addr_ok;
    assign q_pop  = mem.data_ok && !q_empty && !rst;

    assign inst.data_ok = q_pop && (q_head == INST);
    assign data.data_ok = q_pop && (q_head == DATA);

    assign inst.rdata = mem.rdata;
    assign data.rdata = mem.rdata;

    arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .din   (win_id),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Latch the stalled master on an unaccepted request; release on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            hold_id <= INST;
        end else begin
            case (state)
                ARB: begin
                    if (grant_req && !mem.addr_ok) begin
                        hold_id <= win_id;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (mem.addr_ok) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (mem.data_ok && q_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, 4, depth of the in-order response tracking queue (power of two, at least 2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 inst_req, inst_wr  in  1 each  instruction-fetch master request / write flag (master ID 0).
REQ-005 inst_size  in  2, inst_wstrb  in  4, inst_addr  in  32, inst_wdata  in  32  instruction-fetch request payload.
REQ-006 inst_addr_ok, inst_data_ok  out  1 each; inst_rdata  out  32  instruction-fetch master responses.
REQ-007 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master, same meaning as the inst_ fields (master ID 1).
REQ-008 data_addr_ok, data_data_ok  out  1 each; data_rdata  out  32  data master responses.
REQ-009 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared downstream port request.
REQ-010 mem_addr_ok, mem_data_ok  in  1 each; mem_rdata  in  32  shared downstream port responses.
REQ-011 err_orphan  out  1  sticky flag: mem_data_ok received with no outstanding request.

Function
REQ-012 The block SHALL share one SRAM-like port between two masters using req/addr_ok (address phase) and data_ok (data phase) handshakes; responses return in issue order.
REQ-013 FSM states SHALL be ARB and HOLD; reset state ARB.
REQ-014 In ARB, with the queue not full, the winner SHALL be data if data_req=1, otherwise inst if inst_req=1 (fixed data priority); no winner means mem_req=0.
REQ-015 mem_req and all mem_ payload fields SHALL be combinational copies of the winner's inputs, adding zero cycles of latency.
REQ-016 When the queue is full, mem_req SHALL be 0 in ARB and no addr_ok SHALL be returned.
REQ-017 If mem_req=1 and mem_addr_ok=0, the FSM SHALL latch the winner ID and move to HOLD.
REQ-018 In HOLD, the routing SHALL stay on the latched master regardless of the other master's req, until mem_addr_ok=1, then return to ARB.
REQ-019 While in HOLD, mem_req SHALL equal the latched master's req.
REQ-020 <master>_addr_ok SHALL equal mem_addr_ok gated by mem_req and by that master being the current winner or holder; the other master sees 0.
REQ-021 On mem_req && mem_addr_ok, the winner ID SHALL be pushed into the order queue.
REQ-022 On mem_data_ok with the queue non-empty, the head ID SHALL be popped, and the data_ok of that master SHALL be asserted in the same cycle.
REQ-023 Both masters SHALL receive rdata = mem_rdata unconditionally; only data_ok is steered.
REQ-024 A push and a pop in the same cycle SHALL leave the count unchanged, and the pop SHALL return the older head entry.
REQ-025 mem_data_ok with an empty queue SHALL assert no data_ok, SHALL set err_orphan (held until reset) and SHALL leave the count at 0; a same-cycle push still succeeds.
REQ-026 The queue pointers SHALL wrap modulo MAX_OUTSTANDING; the count SHALL be $clog2(MAX_OUTSTANDING+1) bits wide and SHALL never exceed MAX_OUTSTANDING.
REQ-027 Write requests SHALL occupy a queue slot and complete with data_ok exactly like reads.

Reset
REQ-028 Asserting rst SHALL immediately force: FSM ARB, held ID 0, queue count 0, pointers 0, err_orphan 0.
REQ-029 During reset, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL all be 0.
REQ-030 Reset mid-transaction SHALL discard all outstanding entries, and later stray mem_data_ok SHALL set err_orphan.

Structure
REQ-031 Shared package sram_arb_pkg SHALL hold the FSM state type, the master ID constants (INST=0, DATA=1) and the default MAX_OUTSTANDING.
REQ-032 The order queue SHALL be the sub-module arb_order_fifo, a 1-bit-wide synchronous FIFO with push, pop, head, full and empty ports.

Verification
REQ-033 Bench: inst_req and data_req both 1, mem_addr_ok=1 -> data granted, data_addr_ok=1, inst_addr_ok=0; queue head = 1.
REQ-034 Bench: inst_req=1 with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst_addr through HOLD; inst is granted in cycle 4, data in cycle 5.
REQ-035 Bench: issue inst, data, inst with no data_ok, then 3 mem_data_ok pulses -> data_ok order is inst, data, inst; rdata is visible at both masters.
REQ-036 Bench: 4 grants with no responses -> mem_req=0 while requests are pending; one mem_data_ok -> next request granted the following cycle, with count staying at 4.
REQ-037 Bench: mem_data_ok with queue empty -> no data_ok, err_orphan=1 until rst.
REQ-038 Bench: rst pulsed while in HOLD with 2 entries outstanding -> all outputs and state reset asynchronously; next request is granted normally.
